// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-outstanding request sequencer between the CPU core and
// the 16-bit memory array. Write strobe and read enable are registered so the
// array sees glitch-free control; read data is captured and returned as a pulse.
module mem_bus_ctrl #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned READ_WAIT = 1
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              reqValid,
    input  logic              reqWrite,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqWData,
    output logic              reqReady,
    output logic              rspValid,
    output logic [DATA_W-1:0] rspRData,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRe,
    output logic              memWe,
    output logic [DATA_W-1:0] memWBus,
    input  logic [DATA_W-1:0] memRBus
);

    localparam int unsigned CNT_W = 4;

    // READ_WAIT must fit the 4-bit wait counter and be at least one cycle
    if (READ_WAIT < 1 || READ_WAIT > 15) begin : gBadReadWait
        $error("mem_bus_ctrl: READ_WAIT=%0d outside legal range 1..15", READ_WAIT);
    end

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        RD,
        RD_DONE
    } stateE;

    stateE             state, stateNext;
    logic [CNT_W-1:0]  waitCnt, waitCntNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [DATA_W-1:0] memWBusNext;
    logic [DATA_W-1:0] rspRDataNext;
    logic              memReNext;
    logic              memWeNext;
    logic              rspValidNext;

    // Ready is combinational so it follows reset immediately
    assign reqReady = (state == IDLE);

    // State and registered outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= IDLE;
            waitCnt  <= '0;
            memAddr  <= '0;
            memWBus  <= '0;
            rspRData <= '0;
            memRe    <= 1'b0;
            memWe    <= 1'b0;
            rspValid <= 1'b0;
        end else begin
            state    <= stateNext;
            waitCnt  <= waitCntNext;
            memAddr  <= memAddrNext;
            memWBus  <= memWBusNext;
            rspRData <= rspRDataNext;
            memRe    <= memReNext;
            memWe    <= memWeNext;
            rspValid <= rspValidNext;
        end
    end

    // Next-state and next-output decode; registers hold unless a state changes them
    always_comb begin
        stateNext    = state;
        waitCntNext  = waitCnt;
        memAddrNext  = memAddr;
        memWBusNext  = memWBus;
        rspRDataNext = rspRData;
        memReNext    = memRe;
        memWeNext    = memWe;
        rspValidNext = rspValid;

        case (state)
            IDLE: begin
                if (reqValid) begin
                    memAddrNext = reqAddr;
                    memWBusNext = reqWData;
                    if (reqWrite) begin
                        stateNext = W_SETUP;
                    end else begin
                        stateNext   = RD;
                        memReNext   = 1'b1;
                        waitCntNext = CNT_W'(READ_WAIT - 1);
                    end
                end
            end
            W_SETUP: begin
                stateNext = W_STROBE;
                memWeNext = 1'b1;
            end
            W_STROBE: begin
                stateNext    = W_HOLD;
                memWeNext    = 1'b0;
                rspValidNext = 1'b1;
            end
            W_HOLD: begin
                stateNext    = IDLE;
                rspValidNext = 1'b0;
            end
            RD: begin
                if (waitCnt != '0) begin
                    waitCntNext = waitCnt - CNT_W'(1);
                end else begin
                    rspRDataNext = memRBus;
                    memReNext    = 1'b0;
                    rspValidNext = 1'b1;
                    stateNext    = RD_DONE;
                end
            end
            RD_DONE: begin
                stateNext    = IDLE;
                rspValidNext = 1'b0;
            end
            default: begin
                stateNext    = IDLE;
                memReNext    = 1'b0;
                memWeNext    = 1'b0;
                rspValidNext = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (READ_WAIT=1 and 3) share one request
// stream; each has its own memory array and a transaction-level timing model.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        nRst;
    logic        reqValid;
    logic        reqWrite;
    logic [15:0] reqAddr;
    logic [15:0] reqWData;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gInst
        localparam int RW = (g == 0) ? 1 : 3;

        logic        reqReady, rspValid, memRe, memWe;
        logic [15:0] rspRData, memAddr, memWBus, memRBus;
        logic [15:0] arr [0:255] = '{default: 16'h0000};
        logic [15:0] refMem [0:255];

        mem_bus_ctrl #(
            .ADDR_W   (16),
            .DATA_W   (16),
            .READ_WAIT(RW)
        ) dut (
            .clk     (clk),
            .nRst    (nRst),
            .reqValid(reqValid),
            .reqWrite(reqWrite),
            .reqAddr (reqAddr),
            .reqWData(reqWData),
            .reqReady(reqReady),
            .rspValid(rspValid),
            .rspRData(rspRData),
            .memAddr (memAddr),
            .memRe   (memRe),
            .memWe   (memWe),
            .memWBus (memWBus),
            .memRBus (memRBus)
        );

        // Memory array: drives a marker when not enabled, commits on memWe rise
        assign memRBus = memRe ? arr[memAddr[7:0]] : 16'hDEAD;
        always @(posedge memWe) arr[memAddr[7:0]] = memWBus;

        // Reference model: tracks cycles since acceptance of the current request
        initial begin : model
            bit          busy;
            bit          op;
            int          t;
            logic [15:0] eAddr, eWData, eRData;
            string       pfx;
            pfx    = $sformatf("rw%0d ", RW);
            busy   = 1'b0;
            op     = 1'b0;
            t      = 0;
            eAddr  = '0;
            eWData = '0;
            eRData = '0;
            for (int i = 0; i < 256; i++) refMem[i] = 16'h0000;
            forever begin
                @(posedge clk);
                if (!nRst) begin
                    busy   = 1'b0;
                    t      = 0;
                    eAddr  = '0;
                    eWData = '0;
                    eRData = '0;
                end else if (busy) begin
                    t++;
                    if (op && t == 2) refMem[eAddr[7:0]] = eWData;
                    if (!op && t == RW + 1) eRData = refMem[eAddr[7:0]];
                    if (t == (op ? 4 : RW + 2)) busy = 1'b0;
                end else if (reqValid) begin
                    busy   = 1'b1;
                    t      = 1;
                    op     = reqWrite;
                    eAddr  = reqAddr;
                    eWData = reqWData;
                end
                #1;
                checkVal({pfx, "reqReady"}, 32'(reqReady), 32'(!busy));
                checkVal({pfx, "memWe"},    32'(memWe),    32'(busy && op && t == 2));
                checkVal({pfx, "memRe"},    32'(memRe),    32'(busy && !op && t <= RW));
                checkVal({pfx, "rspValid"}, 32'(rspValid), 32'(busy && (op ? t == 3 : t == RW + 1)));
                checkVal({pfx, "memAddr"},  32'(memAddr),  32'(eAddr));
                checkVal({pfx, "memWBus"},  32'(memWBus),  32'(eWData));
                checkVal({pfx, "rspRData"}, 32'(rspRData), 32'(eRData));
            end
        end
    end

    task automatic waitNeg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic putReq(input logic wr, input logic [15:0] addr, input logic [15:0] data);
        reqValid = 1'b1;
        reqWrite = wr;
        reqAddr  = addr;
        reqWData = data;
    endtask

    // Outputs of both instances must be at reset values right after nRst falls
    task automatic checkResetOutputs(input string tag);
        checkVal({tag, " rw1 reqReady"}, 32'(gInst[0].reqReady), 32'd1);
        checkVal({tag, " rw1 memWe"},    32'(gInst[0].memWe),    32'd0);
        checkVal({tag, " rw1 memRe"},    32'(gInst[0].memRe),    32'd0);
        checkVal({tag, " rw1 rspValid"}, 32'(gInst[0].rspValid), 32'd0);
        checkVal({tag, " rw1 memAddr"},  32'(gInst[0].memAddr),  32'd0);
        checkVal({tag, " rw1 memWBus"},  32'(gInst[0].memWBus),  32'd0);
        checkVal({tag, " rw1 rspRData"}, 32'(gInst[0].rspRData), 32'd0);
        checkVal({tag, " rw3 reqReady"}, 32'(gInst[1].reqReady), 32'd1);
        checkVal({tag, " rw3 memWe"},    32'(gInst[1].memWe),    32'd0);
        checkVal({tag, " rw3 memRe"},    32'(gInst[1].memRe),    32'd0);
        checkVal({tag, " rw3 rspValid"}, 32'(gInst[1].rspValid), 32'd0);
        checkVal({tag, " rw3 memAddr"},  32'(gInst[1].memAddr),  32'd0);
    endtask

    initial begin
        nRst     = 1'b0;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        reqAddr  = '0;
        reqWData = '0;
        #2;
        checkResetOutputs("initReset");
        waitNeg(2);
        nRst = 1'b1;
        waitNeg(2);

        // Plain write then reads of the same word
        putReq(1'b1, 16'h0005, 16'h1234);
        waitNeg(1);
        reqValid = 1'b0;
        waitNeg(6);
        checkVal("rw1 word5 after write", 32'(gInst[0].arr[5]), 32'h1234);
        checkVal("rw3 word5 after write", 32'(gInst[1].arr[5]), 32'h1234);
        putReq(1'b0, 16'h0005, 16'h0000);
        waitNeg(1);
        reqValid = 1'b0;
        waitNeg(8);
        checkVal("rw1 read word5", 32'(gInst[0].rspRData), 32'h1234);
        checkVal("rw3 read word5", 32'(gInst[1].rspRData), 32'h1234);

        // reqValid held high across a write followed by a read
        putReq(1'b1, 16'h0002, 16'hA5A5);
        waitNeg(1);
        putReq(1'b0, 16'h0002, 16'h0000);
        waitNeg(4);
        reqValid = 1'b0;
        waitNeg(8);
        checkVal("rw1 held read", 32'(gInst[0].rspRData), 32'hA5A5);
        checkVal("rw3 held read", 32'(gInst[1].rspRData), 32'hA5A5);

        // Requests presented while busy are dropped
        putReq(1'b1, 16'h0009, 16'h5555);
        waitNeg(1);
        putReq(1'b0, 16'h0003, 16'h0000);
        waitNeg(1);
        reqValid = 1'b0;
        waitNeg(6);
        putReq(1'b0, 16'h0009, 16'h0000);
        waitNeg(1);
        putReq(1'b1, 16'h000A, 16'h7777);
        waitNeg(1);
        reqValid = 1'b0;
        waitNeg(8);
        checkVal("rw1 busy memAddr", 32'(gInst[0].memAddr), 32'h0009);
        checkVal("rw3 busy memAddr", 32'(gInst[1].memAddr), 32'h0009);
        checkVal("rw1 busy word10",  32'(gInst[0].arr[10]), 32'h0000);
        checkVal("rw3 busy read9",   32'(gInst[1].rspRData), 32'h5555);

        // Reset during write setup: no commit
        putReq(1'b1, 16'h0007, 16'hFFFF);
        waitNeg(1);
        reqValid = 1'b0;
        #2 nRst = 1'b0;
        #1 checkResetOutputs("resetInSetup");
        waitNeg(1);
        nRst = 1'b1;
        waitNeg(2);
        checkVal("rw1 word7 aborted", 32'(gInst[0].arr[7]), 32'h0000);
        checkVal("rw3 word7 aborted", 32'(gInst[1].arr[7]), 32'h0000);

        // Reset during the strobe: write already committed
        putReq(1'b1, 16'h0007, 16'hFFFF);
        waitNeg(1);
        reqValid = 1'b0;
        waitNeg(1);
        #2 nRst = 1'b0;
        #1 checkResetOutputs("resetInStrobe");
        waitNeg(1);
        nRst = 1'b1;
        waitNeg(2);
        checkVal("rw1 word7 committed", 32'(gInst[0].arr[7]), 32'hFFFF);
        checkVal("rw3 word7 committed", 32'(gInst[1].arr[7]), 32'hFFFF);

        // Random traffic over a small address window
        for (int c = 0; c < 500; c++) begin
            reqValid = ($urandom_range(0, 2) != 0);
            reqWrite = 1'($urandom_range(0, 1));
            reqAddr  = 16'($urandom_range(0, 15));
            reqWData = 16'($urandom);
            waitNeg(1);
        end
        reqValid = 1'b0;
        waitNeg(10);

        for (int i = 0; i < 16; i++) begin
            checkVal($sformatf("rw1 final word%0d", i), 32'(gInst[0].arr[i]), 32'(gInst[0].refMem[i]));
            checkVal($sformatf("rw3 final word%0d", i), 32'(gInst[1].arr[i]), 32'(gInst[1].refMem[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
